seq_divider_16bit: RTL and testbench

- Multi-cycle signed 16-bit restoring divider for the single-cycle processor's execute stage.
- Performs repeated subtraction, one quotient bit per clock, behind a start/busy/done handshake.
- Saturates on overflow and on divide-by-zero, using the same 16'h7FFF / 16'h8000 rule as the saturating adder.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step_16bit.sv | 27 ++
 rtl/seq_divider_16bit.sv | 128 ++++++++++++
 tb/tb_seq_divider_16bit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and constants for the sequential divider
package div_pkg;

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} div_state_t;

   localparam int                   DIV_WIDTH = 16;
   localparam int                   DIV_ITER  = DIV_WIDTH;
   localparam logic [DIV_WIDTH-1:0] SAT_POS   = 16'h7FFF;
   localparam logic [DIV_WIDTH-1:0] SAT_NEG   = 16'h8000;
   localparam int                   CNT_W     = $clog2(DIV_ITER);

endpackage

// File: rtl/div_step_16bit.sv
// rtl/div_step_16bit.sv - one restoring-division step on magnitudes
// Shifts {rem,quo} left once and subtracts |divisor| when it fits.
module div_step_16bit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] part_rem,
   input  logic [WIDTH-1:0] part_quo,
   input  logic [WIDTH:0]   dvs_mag,
   output logic [WIDTH-1:0] next_rem,
   output logic [WIDTH-1:0] next_quo
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // part_rem < dvs_mag always holds, so the shifted value fits WIDTH+1 bits
   // and trial's top bit is a clean "did not fit" flag.
   always_comb begin
      shifted  = {part_rem, part_quo[WIDTH-1]};
      trial    = shifted - dvs_mag;
      next_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      next_quo = {part_quo[WIDTH-2:0], ~trial[WIDTH]};
   end

endmodule

// File: rtl/seq_divider_16bit.sv
// rtl/seq_divider_16bit.sv - signed 16-bit restoring divider, start/busy/done handshake
// Optional macro DIV_EARLY_TERM_EN: finish in PREP when |dividend| < |divisor|.
module seq_divider_16bit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic             ovfl
);

   localparam logic [WIDTH-1:0] SAT_P = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_N = {1'b1, {(WIDTH-1){1'b0}}};
   localparam int               CW    = (ITER > 1) ? $clog2(ITER) : 1;

   div_state_t       state, state_nx;
   logic [WIDTH-1:0] dvd, dvs, rem, quo;
   logic [WIDTH-1:0] abs_dvd, abs_dvs, step_rem, step_quo;
   logic [CW-1:0]    cnt;
   logic             q_neg, r_neg;
   logic             accept, zero_dvs, sat_case, small_case;

   always_comb begin
      abs_dvd  = dvd[WIDTH-1] ? -dvd : dvd;
      abs_dvs  = dvs[WIDTH-1] ? -dvs : dvs;
      zero_dvs = (dvs == '0);
      sat_case = (dvd == SAT_N) && (dvs == '1);
      accept   = start && ((state == IDLE) || (state == DONE));
`ifdef DIV_EARLY_TERM_EN
      small_case = (abs_dvd < abs_dvs);
`else
      small_case = 1'b0;
`endif
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = PREP;
         PREP: state_nx = (zero_dvs || sat_case || small_case) ? DONE : CALC;
         CALC: if (cnt == CW'(ITER - 1)) state_nx = FIX;
         FIX:  state_nx = DONE;
         DONE: state_nx = start ? PREP : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   div_step_16bit #(.WIDTH(WIDTH)) u_step (
      .part_rem (rem),
      .part_quo (quo),
      .dvs_mag  ({1'b0, abs_dvs}),
      .next_rem (step_rem),
      .next_quo (step_quo)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         dvd         <= '0;
         dvs         <= '0;
         rem         <= '0;
         quo         <= '0;
         cnt         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         ovfl        <= 1'b0;
      end else begin
         state <= state_nx;
         // Outputs trail the state by one edge so results and flags are
         // already stable in the cycle done is high.
         busy  <= (state == PREP) || (state == CALC) || (state == FIX);
         done  <= (state == DONE);
         if (accept) begin
            dvd <= dividend;
            dvs <= divisor;
         end
         case (state)
            PREP: begin
               rem         <= '0;
               quo         <= abs_dvd;
               cnt         <= '0;
               q_neg       <= dvd[WIDTH-1] ^ dvs[WIDTH-1];
               r_neg       <= dvd[WIDTH-1];
               div_by_zero <= 1'b0;
               ovfl        <= 1'b0;
               if (zero_dvs) begin
                  quotient    <= dvd[WIDTH-1] ? SAT_N : SAT_P;
                  remainder   <= dvd;
                  div_by_zero <= 1'b1;
               end else if (sat_case) begin
                  quotient  <= SAT_P;
                  remainder <= '0;
                  ovfl      <= 1'b1;
               end else if (small_case) begin
                  quotient  <= '0;
                  remainder <= dvd;
               end
            end
            CALC: begin
               rem <= step_rem;
               quo <= step_quo;
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               quotient  <= q_neg ? -quo : quo;
               remainder <= r_neg ? -rem : rem;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb/tb_seq_divider_16bit.sv - self-checking bench for seq_divider_16bit
module tb_seq_divider_16bit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic [15:0] quotient, remainder;
   logic        busy, done, div_by_zero, ovfl;

   int checks = 0;
   int errors = 0;

   seq_divider_16bit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .ovfl        (ovfl)
   );

   always #5 clk = ~clk;

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Truncating signed division with the saturation rules.
   function automatic void model_res(input logic [15:0] a16, input logic [15:0] b16,
                                     output logic [15:0] q, output logic [15:0] r,
                                     output logic dz, output logic ov);
      int a, b;
      a  = int'($signed(a16));
      b  = int'($signed(b16));
      dz = 1'b0;
      ov = 1'b0;
      if (b == 0) begin
         q  = (a < 0) ? 16'h8000 : 16'h7FFF;
         r  = a16;
         dz = 1'b1;
      end else if (a == -32768 && b == -1) begin
         q  = 16'h7FFF;
         r  = 16'h0000;
         ov = 1'b1;
      end else begin
         q = 16'(a / b);
         r = 16'(a % b);
      end
   endfunction

   function automatic int model_lat(input logic [15:0] a16, input logic [15:0] b16);
      int a, b;
      a = int'($signed(a16));
      b = int'($signed(b16));
      if (b == 0 || (a == -32768 && b == -1)) return 2;
`ifdef DIV_EARLY_TERM_EN
      if (((a < 0) ? -a : a) < ((b < 0) ? -b : b)) return 2;
`endif
      return 19;
   endfunction

   // Cycle-level model: one pending operation, completed at a known edge.
   int          e = 0, acc_e = 0, done_e = 0;
   bit          pend = 0, comp = 0;
   logic [15:0] pq, pr, m_q = '0, m_r = '0;
   logic        pdz, pov, m_dz = 1'b0, m_ov = 1'b0;

   always @(posedge clk) begin
      e++;
      comp = 0;
      if (!rst_n) begin
         pend = 0;
         m_q  = '0;
         m_r  = '0;
         m_dz = 1'b0;
         m_ov = 1'b0;
      end else begin
         if (pend && e == done_e) begin
            comp = 1;
            pend = 0;
            m_q  = pq;
            m_r  = pr;
            m_dz = pdz;
            m_ov = pov;
         end
         if (start && !pend) begin
            pend   = 1;
            acc_e  = e;
            done_e = e + model_lat(dividend, divisor);
            model_res(dividend, divisor, pq, pr, pdz, pov);
         end
      end
      #1;
      chk1("busy", busy, pend && (e > acc_e));
      chk1("done", done, comp);
      if (comp || !pend) begin
         chk16("quotient", quotient, m_q);
         chk16("remainder", remainder, m_r);
         chk1("div_by_zero", div_by_zero, m_dz);
         chk1("ovfl", ovfl, m_ov);
      end
   end

   task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic edz, input logic eov, input int elat);
      int k, bc;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k  = 0;
      bc = int'(busy);
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
         bc += int'(busy);
      end
      chkn({tag, " latency"}, k, elat);
      chkn({tag, " busy cycles"}, bc, elat - 1);
      chk16({tag, " quotient"}, quotient, eq);
      chk16({tag, " remainder"}, remainder, er);
      chk1({tag, " div_by_zero"}, div_by_zero, edz);
      chk1({tag, " ovfl"}, ovfl, eov);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int  k;
      int  early_lat;
      bit  seen;
      logic [15:0] q_first;

`ifdef DIV_EARLY_TERM_EN
      early_lat = 2;
`else
      early_lat = 19;
`endif

      repeat (3) @(negedge clk);
      chk16("reset quotient", quotient, 16'h0000);
      chk16("reset remainder", remainder, 16'h0000);
      chk1("reset busy", busy, 1'b0);
      chk1("reset done", done, 1'b0);
      chk1("reset flags", div_by_zero | ovfl, 1'b0);
      rst_n = 1'b1;

      run_div("100/7",    16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 19);
      run_div("-100/7",   16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 19);
      run_div("100/-7",   16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 1'b0, 19);
      run_div("8000/FFFF",16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 2);
      run_div("5/0",      16'd5,    16'd0,    16'h7FFF, 16'd5,    1'b1, 1'b0, 2);
      run_div("-5/0",     16'hFFFB, 16'd0,    16'h8000, 16'hFFFB, 1'b1, 1'b0, 2);
      run_div("-32768/1", 16'h8000, 16'd1,    16'h8000, 16'h0000, 1'b0, 1'b0, 19);
      run_div("-7/-2",    16'hFFF9, 16'hFFFE, 16'd3,    16'hFFFF, 1'b0, 1'b0, 19);
      run_div("3/7",      16'd3,    16'd7,    16'd0,    16'd3,    1'b0, 1'b0, early_lat);

      // start with different operands while the first division runs
      @(negedge clk);
      dividend = 16'd100;
      divisor  = 16'd7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 40) begin
         if (k == 5) begin
            start    = 1'b1;
            dividend = 16'd1000;
            divisor  = 16'd3;
         end
         if (k == 8) start = 1'b0;
         @(negedge clk);
         k++;
      end
      chkn("ignored start latency", k, 19);
      chk16("ignored start quotient", quotient, 16'd14);
      chk16("ignored start remainder", remainder, 16'd2);

      // start held through DONE: second division with no idle gap
      @(negedge clk);
      dividend = 16'd100;
      divisor  = 16'd7;
      start    = 1'b1;
      @(negedge clk);
      dividend = 16'hFF9C;
      k = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      chkn("b2b first latency", k, 19);
      q_first = quotient;
      chk16("b2b first quotient", q_first, 16'd14);
      start = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < 40);
      chkn("b2b second latency", k, 19);
      chk16("b2b second quotient", quotient, 16'hFFF2);
      chk16("b2b second remainder", remainder, 16'hFFFE);

      // reset in the middle of CALC
      @(negedge clk);
      dividend = 16'd100;
      divisor  = 16'd7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk16("midreset quotient", quotient, 16'h0000);
      chk16("midreset remainder", remainder, 16'h0000);
      chk1("midreset busy", busy, 1'b0);
      chk1("midreset done", done, 1'b0);
      rst_n = 1'b1;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         seen |= done;
      end
      chk1("midreset no done pulse", seen, 1'b0);
      run_div("7FFF/1", 16'h7FFF, 16'd1, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 19);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
